// File: rtl/divu32_seq.sv
// Sequential unsigned restoring divider: one quotient bit per cycle, trial
// subtraction done on a carry-lookahead add path (a + ~b + 1).
module divu32_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    // state | meaning
    // IDLE  | waiting for start; results from the last operation held
    // CALC  | one restoring iteration per cycle (single pass if divisor is 0)
    // DONE  | done pulse cycle; start ignored
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // 32-bit adder: 4-bit lookahead groups, group carries chained by G/P.
    function automatic logic [32:0] adder32(
        input logic [31:0] a,
        input logic [31:0] b,
        input logic        c0
    );
        logic [31:0] g;
        logic [31:0] p;
        logic [31:0] c;
        logic [7:0]  gg;
        logic [7:0]  gp;
        logic [8:0]  bc;
        g = a & b;
        p = a ^ b;
        for (int k = 0; k < 8; k++) begin
            gp[k] = &p[4*k +: 4];
            gg[k] = g[4*k+3]
                  | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
        end
        bc[0] = c0;
        for (int k = 0; k < 8; k++) begin
            bc[k+1] = gg[k] | (gp[k] & bc[k]);
        end
        for (int k = 0; k < 8; k++) begin
            c[4*k]   = bc[k];
            c[4*k+1] = g[4*k] | (p[4*k] & bc[k]);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k])
                     | (p[4*k+1] & p[4*k] & bc[k]);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
                     | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & bc[k]);
        end
        return {bc[8], p ^ c};
    endfunction

    state_t           state;
    logic [WIDTH-1:0] q_work;
    logic [WIDTH-1:0] rem_work;
    logic [WIDTH-1:0] div_reg;
    logic [4:0]       count;

    logic [WIDTH:0]   trial;
    logic [32:0]      sub_res;
    logic             accept;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] q_next;

    // trial[WIDTH] set means the shifted remainder already exceeds any divisor
    always_comb begin
        trial    = {rem_work, q_work[WIDTH-1]};
        sub_res  = adder32(trial[WIDTH-1:0], ~div_reg, 1'b1);
        accept   = trial[WIDTH] | sub_res[32];
        rem_next = accept ? sub_res[WIDTH-1:0] : trial[WIDTH-1:0];
        q_next   = {q_work[WIDTH-2:0], accept};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            q_work      <= '0;
            rem_work    <= '0;
            div_reg     <= '0;
            count       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        q_work   <= dividend;
                        div_reg  <= divisor;
                        rem_work <= '0;
                        count    <= '0;
                        busy     <= 1'b1;
                        state    <= CALC;
                        if (divisor != '0) begin
                            div_by_zero <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    // q_work still holds the untouched dividend on a zero divisor
                    if (div_reg == '0) begin
                        quotient    <= '1;
                        remainder   <= q_work;
                        div_by_zero <= 1'b1;
                        done        <= 1'b1;
                        state       <= DONE;
                    end else begin
                        rem_work <= rem_next;
                        q_work   <= q_next;
                        count    <= count + 5'd1;
                        if (count == 5'(WIDTH - 1)) begin
                            quotient  <= q_next;
                            remainder <= rem_next;
                            done      <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divu32_seq.sv
// Bench for divu32_seq: transaction-level reference model compared every
// cycle, directed literal cases, and a randomized operand regression.
module tb_divu32_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int checks = 0;
    int errors = 0;
    int printed = 0;

    divu32_seq #(.WIDTH(32)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .dividend(dividend),
        .divisor(divisor),
        .busy(busy),
        .done(done),
        .quotient(quotient),
        .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (printed < 40) begin
                printed++;
                $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
            end
        end
    endtask

    // Reference model: latency countdown plus arithmetic results.
    logic        m_busy;
    logic        m_done;
    logic [31:0] m_q;
    logic [31:0] m_r;
    logic        m_dz;
    int          m_left;
    logic [31:0] p_q;
    logic [31:0] p_r;
    logic        p_dz;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_q    = '0;
            m_r    = '0;
            m_dz   = 1'b0;
            m_left = 0;
        end else begin
            m_done = 1'b0;
            if (!m_busy) begin
                if (start) begin
                    m_busy = 1'b1;
                    if (divisor == 32'd0) begin
                        m_left = 1;
                        p_q    = 32'hFFFF_FFFF;
                        p_r    = dividend;
                        p_dz   = 1'b1;
                    end else begin
                        m_left = 32;
                        p_q    = dividend / divisor;
                        p_r    = dividend % divisor;
                        p_dz   = 1'b0;
                        m_dz   = 1'b0;
                    end
                end
            end else if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_done = 1'b1;
                    m_q    = p_q;
                    m_r    = p_r;
                    m_dz   = p_dz;
                end
            end else begin
                m_busy = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        chk("cyc_busy", 64'(busy), 64'(m_busy));
        chk("cyc_done", 64'(done), 64'(m_done));
        chk("cyc_quotient", 64'(quotient), 64'(m_q));
        chk("cyc_remainder", 64'(remainder), 64'(m_r));
        chk("cyc_div_by_zero", 64'(div_by_zero), 64'(m_dz));
    end

    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!done) chk("done_timeout", 64'(lat), 64'd0);
    endtask

    task automatic op(input logic [31:0] a, input logic [31:0] b,
                      output logic [31:0] q, output logic [31:0] r,
                      output logic dz, output int lat);
        @(posedge clk);
        #1;
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        wait_done(lat);
        q  = quotient;
        r  = remainder;
        dz = div_by_zero;
    endtask

    task automatic op_lit(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eq, input logic [31:0] er,
                          input logic edz, input int elat);
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        int          lat;
        op(a, b, q, r, dz, lat);
        chk({name, "_lat"}, 64'(lat), 64'(elat));
        chk({name, "_q"}, 64'(q), 64'(eq));
        chk({name, "_r"}, 64'(r), 64'(er));
        chk({name, "_dz"}, 64'(dz), 64'(edz));
        chk({name, "_busy_at_done"}, 64'(busy), 64'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        int          lat;
        int          sel;

        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_q", 64'(quotient), 64'd0);
        chk("reset_r", 64'(remainder), 64'd0);
        chk("reset_dz", 64'(div_by_zero), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        op_lit("d100_7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 32);
        op_lit("d5_9", 32'd5, 32'd9, 32'd0, 32'd5, 1'b0, 32);
        op_lit("dmax_1", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 32);
        op_lit("dmax_8001", 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 32'h7FFF_FFFE, 1'b0, 32);
        op_lit("d1234_0", 32'd1234, 32'd0, 32'hFFFF_FFFF, 32'd1234, 1'b1, 1);
        op_lit("d9_3", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 32);

        // start held high through CALC and DONE with different operands
        @(posedge clk);
        #1;
        start    = 1'b1;
        dividend = 32'd100;
        divisor  = 32'd7;
        @(posedge clk);
        #1;
        dividend = 32'd50;
        divisor  = 32'd5;
        wait_done(lat);
        chk("hold_first_lat", 64'(lat), 64'd32);
        chk("hold_first_q", 64'(quotient), 64'd14);
        chk("hold_first_r", 64'(remainder), 64'd2);
        @(posedge clk);
        #1;
        chk("hold_idle_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("hold_second_busy", 64'(busy), 64'd1);
        wait_done(lat);
        chk("hold_second_lat", 64'(lat), 64'd32);
        chk("hold_second_q", 64'(quotient), 64'd10);
        chk("hold_second_r", 64'(remainder), 64'd0);

        // reset in the middle of 1000/3
        @(posedge clk);
        #1;
        start    = 1'b1;
        dividend = 32'd1000;
        divisor  = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_q", 64'(quotient), 64'd0);
        chk("midrst_r", 64'(remainder), 64'd0);
        chk("midrst_dz", 64'(div_by_zero), 64'd0);
        repeat (30) begin
            @(posedge clk);
            #1;
            chk("midrst_no_done", 64'(done), 64'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        op_lit("d1000_3", 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, 32);

        for (int i = 0; i < 1200; i++) begin
            a   = $urandom;
            b   = $urandom;
            sel = $urandom_range(0, 9);
            case (sel)
                0: b = 32'd1;
                1: b = a;
                2: b = 32'd0;
                3: b = 32'($urandom_range(1, 15));
                4: a = 32'($urandom_range(0, 100));
                5: b = b | 32'h8000_0000;
                6: b = b >> $urandom_range(0, 31);
                default: ;
            endcase
            op(a, b, q, r, dz, lat);
            if (b == 32'd0) begin
                chk("rnd_dz_lat", 64'(lat), 64'd1);
                chk("rnd_dz_q", 64'(q), 64'hFFFF_FFFF);
                chk("rnd_dz_r", 64'(r), 64'(a));
                chk("rnd_dz_flag", 64'(dz), 64'd1);
            end else begin
                chk("rnd_lat", 64'(lat), 64'd32);
                chk("rnd_identity", 64'(q) * 64'(b) + 64'(r), 64'(a));
                chk("rnd_r_lt_b", 64'(r < b), 64'd1);
                chk("rnd_flag", 64'(dz), 64'd0);
            end
        end

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
